// File: rtl/shift_reg_univ.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shift_reg_univ                                                  |
// | Function : universal shift register: hold/load/shift/rotate plus counted   |
// |            right-shift bursts with busy/done status.                       |
// |            Define ASYNC_SET_EN for an asynchronous set; default is sync.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module shift_reg_univ #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}},
   parameter int               CW        = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   input  logic [CW-1:0]    len,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] c_mode_hold  = 3'b000;
   localparam logic [2:0] c_mode_load  = 3'b001;
   localparam logic [2:0] c_mode_shl   = 3'b010;
   localparam logic [2:0] c_mode_shr   = 3'b011;
   localparam logic [2:0] c_mode_rol   = 3'b100;
   localparam logic [2:0] c_mode_ror   = 3'b101;
   localparam logic [2:0] c_mode_burst = 3'b110;
   localparam logic [CW-1:0] c_width   = CW'(WIDTH);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [WIDTH-1:0] r_q, w_q_nxt;
   logic             r_sout, w_sout_nxt;
   logic             r_done, w_done_nxt;
   logic [CW-1:0]    w_len_clamp;

   assign w_len_clamp = (len > c_width) ? c_width : len;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_q_nxt     = r_q;
      w_sout_nxt  = r_sout;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (en) begin
               case (mode)
                  c_mode_load: w_q_nxt = d;
                  c_mode_shl: begin
                     w_q_nxt    = {r_q[WIDTH-2:0], sin};
                     w_sout_nxt = r_q[WIDTH-1];
                  end
                  c_mode_shr: begin
                     w_q_nxt    = {sin, r_q[WIDTH-1:1]};
                     w_sout_nxt = r_q[0];
                  end
                  c_mode_rol: begin
                     w_q_nxt    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                     w_sout_nxt = r_q[WIDTH-1];
                  end
                  c_mode_ror: begin
                     w_q_nxt    = {r_q[0], r_q[WIDTH-1:1]};
                     w_sout_nxt = r_q[0];
                  end
                  c_mode_burst: begin
                     // A zero-length burst completes at once: done only, no RUN.
                     w_cnt_nxt = w_len_clamp;
                     if (w_len_clamp == '0) begin
                        w_done_nxt = 1'b1;
                     end else begin
                        w_state_nxt = S_RUN;
                     end
                  end
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            // en low stalls the burst without aborting it; mode is ignored here.
            if (en) begin
               w_q_nxt    = {sin, r_q[WIDTH-1:1]};
               w_sout_nxt = r_q[0];
               w_cnt_nxt  = r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  w_state_nxt = S_IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

`ifdef ASYNC_SET_EN
   always_ff @(posedge clk or posedge reset or posedge set) begin
`else
   always_ff @(posedge clk or posedge reset) begin
`endif
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_q     <= '0;
         r_sout  <= 1'b0;
         r_done  <= 1'b0;
      end else if (set) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_q     <= SET_VALUE;
         r_sout  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_q     <= w_q_nxt;
         r_sout  <= w_sout_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign q    = r_q;
   assign sout = r_sout;
   assign busy = (r_state == S_RUN);
   assign done = r_done;

endmodule
`default_nettype wire
